pmem_line_adaptor: RTL

- Responder on the 256-bit cache-line physical-memory interface driven by the L2 cache's pmem_* port.
- Converts each line read/write into a 4-beat, 64-bit burst transaction on the DRAM/burst memory interface.
- Sits between the L2 cache and the physical memory model/controller; one outstanding transaction at a time.

---
 rtl/pmem_adaptor_pkg.sv | 26 ++
 rtl/pmem_beat_shifter.sv | 59 +++++
 rtl/pmem_line_adaptor.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pmem_adaptor_pkg.sv
// ============================================================================
// Module      : pmem_adaptor_pkg
// Description : Shared constants and state type for the cache-line to burst
//               memory adaptor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pmem_adaptor_pkg;

    localparam int c_LINE_W      = 256;
    localparam int c_BEAT_W      = 64;
    localparam int c_BEATS       = c_LINE_W / c_BEAT_W;
    localparam int c_OFFSET_BITS = 5;
    localparam int c_BEAT_IDX_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adaptor_state_t;

endpackage

`default_nettype wire

// File: rtl/pmem_beat_shifter.sv
// ============================================================================
// Module      : pmem_beat_shifter
// Description : Read-line assembly buffer, write-line holding buffer and the
//               beat index shared by both directions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmem_beat_shifter
    import pmem_adaptor_pkg::*;
#(
    parameter int LINE_W = c_LINE_W,
    parameter int BEAT_W = c_BEAT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [LINE_W-1:0]       load_line,
    input  logic                    capture,
    input  logic [BEAT_W-1:0]       beat_in,
    input  logic                    advance,
    input  logic                    clear,
    output logic [c_BEAT_IDX_W-1:0] beat_idx,
    output logic [LINE_W-1:0]       rd_line,
    output logic [BEAT_W-1:0]       beat_out
);

    logic [c_BEAT_IDX_W-1:0] r_idx;
    logic [LINE_W-1:0]       r_rd_line;
    logic [LINE_W-1:0]       r_wr_line;

    // Separate buffers so a write never disturbs the last read line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_rd_line <= '0;
            r_wr_line <= '0;
        end else begin
            if (load) begin
                r_wr_line <= load_line;
            end
            if (capture) begin
                r_rd_line[BEAT_W*r_idx +: BEAT_W] <= beat_in;
            end
            if (clear) begin
                r_idx <= '0;
            end else if (advance) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign beat_idx = r_idx;
    assign rd_line  = r_rd_line;
    assign beat_out = r_wr_line[BEAT_W*r_idx +: BEAT_W];

endmodule

`default_nettype wire

// File: rtl/pmem_line_adaptor.sv
// ============================================================================
// Module      : pmem_line_adaptor
// Description : Turns 256-bit line read/write requests into 4-beat 64-bit
//               bursts. Optional watchdog under macro PMEM_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmem_line_adaptor
    import pmem_adaptor_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = c_LINE_W,
    parameter int BEAT_W  = c_BEAT_W,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [ADDR_W-1:0] line_address,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [LINE_W-1:0] line_rdata,
    output logic              line_resp,
    output logic              burst_read,
    output logic              burst_write,
    output logic [ADDR_W-1:0] burst_address,
    output logic [BEAT_W-1:0] burst_wdata,
    input  logic [BEAT_W-1:0] burst_rdata,
`ifdef PMEM_WATCHDOG_EN
    input  logic              burst_resp,
    output logic              burst_timeout
`else
    input  logic              burst_resp
`endif
);

    localparam logic [c_BEAT_IDX_W-1:0] c_LAST_BEAT = c_BEAT_IDX_W'(c_BEATS - 1);

    adaptor_state_t          r_state;
    adaptor_state_t          w_state_next;
    logic [ADDR_W-1:0]       r_burst_address;
    logic [c_BEAT_IDX_W-1:0] w_beat_idx;
    logic                    w_load;
    logic                    w_capture;
    logic                    w_advance;
    logic                    w_clear;
    logic                    w_accept;
    logic                    w_active;
    logic                    w_wd_expire;
    logic [c_OFFSET_BITS-1:0] w_unused_offset;

    assign w_unused_offset = line_address[c_OFFSET_BITS-1:0];
    assign w_active        = (r_state == READ) || (r_state == WRITE);

`ifdef PMEM_WATCHDOG_EN
    localparam int c_WD_W = $clog2(TIMEOUT + 1);

    logic [c_WD_W-1:0] r_wd_cnt;
    logic              r_timeout;

    // Expires on the cycle that would bring the idle count up to TIMEOUT.
    assign w_wd_expire = w_active && !burst_resp && (r_wd_cnt == c_WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_active && !burst_resp) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end else begin
                r_wd_cnt <= '0;
            end
            if (w_wd_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign burst_timeout = r_timeout;
`else
    localparam int c_UNUSED_TIMEOUT = TIMEOUT;

    assign w_wd_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        w_clear      = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (line_write) begin
                    w_accept     = 1'b1;
                    w_load       = 1'b1;
                    w_state_next = WRITE;
                end else if (line_read) begin
                    w_accept     = 1'b1;
                    w_state_next = READ;
                end
            end
            READ: begin
                if (burst_resp) begin
                    w_capture = 1'b1;
                    w_advance = 1'b1;
                    if (w_beat_idx == c_LAST_BEAT) begin
                        w_state_next = DONE;
                    end
                end else if (w_wd_expire) begin
                    w_state_next = DONE;
                end
            end
            WRITE: begin
                if (burst_resp) begin
                    w_advance = 1'b1;
                    if (w_beat_idx == c_LAST_BEAT) begin
                        w_state_next = DONE;
                    end
                end else if (w_wd_expire) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_clear      = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_burst_address <= '0;
        end else if (w_accept) begin
            r_burst_address <= {line_address[ADDR_W-1:c_OFFSET_BITS], {c_OFFSET_BITS{1'b0}}};
        end
    end

    pmem_beat_shifter #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .load_line (line_wdata),
        .capture   (w_capture),
        .beat_in   (burst_rdata),
        .advance   (w_advance),
        .clear     (w_clear),
        .beat_idx  (w_beat_idx),
        .rd_line   (line_rdata),
        .beat_out  (burst_wdata)
    );

    // Strobes decode the state register and are masked while rst is high.
    assign burst_read    = (r_state == READ)  && !rst;
    assign burst_write   = (r_state == WRITE) && !rst;
    assign line_resp     = (r_state == DONE)  && !rst;
    assign burst_address = r_burst_address;

endmodule

`default_nettype wire
